// File: rtl/mac_stream_arbiter.sv
// Packet round-robin arbiter sharing one staged MAC; results return tagged by requester.
// Define MAC_ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority instead of round-robin.
module mac_stream_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [NUM_REQ-1:0]    S_AXIS_TVALID,
  input  logic [16*NUM_REQ-1:0] S_AXIS_TDATA,
  input  logic [NUM_REQ-1:0]    S_AXIS_TLAST,
  output logic [NUM_REQ-1:0]    S_AXIS_TREADY,
  output logic                  M_AXIS_TVALID,
  output logic [15:0]           M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  input  logic                  R_AXIS_TVALID,
  input  logic [31:0]           R_AXIS_TDATA,
  input  logic                  R_AXIS_TLAST,
  output logic                  R_AXIS_TREADY,
  output logic                  O_AXIS_TVALID,
  output logic [31:0]           O_AXIS_TDATA,
  output logic                  O_AXIS_TLAST,
  output logic [ID_W-1:0]       O_AXIS_TDEST,
  input  logic                  O_AXIS_TREADY
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  state_t            state_q;
  logic [ID_W-1:0]   grant_q;
  logic [ID_W-1:0]   tag_q [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_q;
  logic [PTR_W-1:0]  rd_q;
  logic [PTR_W:0]    cnt_q;

  logic              win;
  logic [ID_W-1:0]   win_id;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              xfer;
  logic              sel_valid;
  logic              sel_last;
  logic [15:0]       sel_data;

`ifndef MAC_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]   last_q;
`endif

  assign full  = (cnt_q == (PTR_W+1)'(TAG_DEPTH));
  assign empty = (cnt_q == '0);
  assign xfer  = (state_q == XFER);

`ifdef MAC_ARB_FIXED_PRIO_EN
  always_comb begin
    win    = 1'b0;
    win_id = '0;
    for (int r = NUM_REQ - 1; r >= 0; r--) begin
      if (S_AXIS_TVALID[r]) begin
        win    = 1'b1;
        win_id = ID_W'(r);
      end
    end
  end
`else
  // Search order begins one past the last winner and wraps.
  always_comb begin
    win    = 1'b0;
    win_id = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!win && S_AXIS_TVALID[r] &&
            ((int'(last_q) + i) % NUM_REQ == r)) begin
          win    = 1'b1;
          win_id = ID_W'(r);
        end
      end
    end
  end
`endif

  assign push = (state_q == IDLE) && !full && win;

  always_comb begin
    sel_valid     = 1'b0;
    sel_last      = 1'b0;
    sel_data      = '0;
    S_AXIS_TREADY = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant_q == ID_W'(r)) begin
        sel_valid        = S_AXIS_TVALID[r];
        sel_last         = S_AXIS_TLAST[r];
        sel_data         = S_AXIS_TDATA[16*r +: 16];
        S_AXIS_TREADY[r] = xfer & M_AXIS_TREADY;
      end
    end
  end

  assign M_AXIS_TVALID = xfer & sel_valid;
  assign M_AXIS_TLAST  = xfer & sel_last;
  assign M_AXIS_TDATA  = xfer ? sel_data : 16'h0;

  assign O_AXIS_TVALID = R_AXIS_TVALID & !empty;
  assign R_AXIS_TREADY = O_AXIS_TREADY & !empty;
  assign O_AXIS_TDATA  = R_AXIS_TDATA;
  assign O_AXIS_TLAST  = O_AXIS_TVALID;
  assign O_AXIS_TDEST  = empty ? '0 : tag_q[rd_q];
  assign pop           = O_AXIS_TVALID & O_AXIS_TREADY;

  // Every result is one beat, so the MAC's TLAST carries no information.
  logic unused_tlast;
  assign unused_tlast = R_AXIS_TLAST;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      grant_q <= '0;
`ifndef MAC_ARB_FIXED_PRIO_EN
      last_q  <= ID_W'(NUM_REQ - 1);
`endif
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (push) begin
            state_q <= XFER;
            grant_q <= win_id;
`ifndef MAC_ARB_FIXED_PRIO_EN
            last_q  <= win_id;
`endif
          end
        end
        XFER: begin
          if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push && !pop)
        cnt_q <= cnt_q + 1'b1;
      else if (!push && pop)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) tag_q[wr_q] <= win_id;
  end

endmodule

// File: tb/tb_mac_stream_arbiter.sv
// Directed bench for mac_stream_arbiter; the bench plays the MAC on M/R ports.
// Results are accumulated from forwarded beats as bias + sum(hi*lo) of signed bytes.
module tb_mac_stream_arbiter;

  localparam int N = 4;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [N-1:0] s_valid;
  logic [N-1:0] s_last;
  logic [N-1:0] s_tready;
  logic [15:0] d_arr [N];
  logic [16*N-1:0] s_data;
  logic        m_tvalid;
  logic [15:0] m_tdata;
  logic        m_tlast;
  logic        m_ready;
  logic        r_valid;
  logic [31:0] r_data;
  logic        r_tready;
  logic        o_tvalid;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic [1:0]  o_tdest;
  logic        o_ready;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  assign s_data = {d_arr[3], d_arr[2], d_arr[1], d_arr[0]};

  mac_stream_arbiter #(.NUM_REQ(4), .ID_W(2), .TAG_DEPTH(4)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXIS_TVALID (s_valid),
    .S_AXIS_TDATA  (s_data),
    .S_AXIS_TLAST  (s_last),
    .S_AXIS_TREADY (s_tready),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TREADY (m_ready),
    .R_AXIS_TVALID (r_valid),
    .R_AXIS_TDATA  (r_data),
    .R_AXIS_TLAST  (1'b1),
    .R_AXIS_TREADY (r_tready),
    .O_AXIS_TVALID (o_tvalid),
    .O_AXIS_TDATA  (o_tdata),
    .O_AXIS_TLAST  (o_tlast),
    .O_AXIS_TDEST  (o_tdest),
    .O_AXIS_TREADY (o_ready)
  );

  // MAC stand-in fed only by beats the arbiter actually forwards.
  logic        mid_q = 1'b0;
  logic [31:0] acc_q = '0;
  logic [31:0] res_q = '0;
  int          beats_q = 0;
  logic signed [7:0]  pa, pb;
  logic signed [15:0] prod;
  logic [31:0] acc_d;

  assign pa    = m_tdata[15:8];
  assign pb    = m_tdata[7:0];
  assign prod  = pa * pb;
  assign acc_d = mid_q ? acc_q + {{16{prod[15]}}, prod}
                       : {{16{m_tdata[15]}}, m_tdata};

  always @(posedge ACLK) begin
    if (ARESET) begin
      mid_q <= 1'b0;
    end else if (m_tvalid && m_ready) begin
      acc_q   <= acc_d;
      mid_q   <= !m_tlast;
      beats_q <= beats_q + 1;
      if (m_tlast) res_q <= acc_d;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic lane(input logic [1:0] r, input logic v,
                      input logic [15:0] d, input logic l);
    s_valid[r] = v;
    d_arr[r]   = d;
    s_last[r]  = l;
  endtask

  logic [1:0] ord [4];
  logic [1:0] dq  [4];
  int         b;
  int         b0;
  logic       mr;
  logic       hs;

  initial begin
    ARESET  = 1'b1;
    s_valid = '0;
    s_last  = '0;
    for (int i = 0; i < N; i++) d_arr[i] = '0;
    m_ready = 1'b1;
    r_valid = 1'b1;
    r_data  = 32'h0;
    o_ready = 1'b1;
    step();
    step();
    chk("rst_s_tready", 32'(s_tready), 0);
    chk("rst_m_tvalid", 32'(m_tvalid), 0);
    chk("rst_m_tlast", 32'(m_tlast), 0);
    chk("rst_m_tdata", 32'(m_tdata), 0);
    chk("rst_r_tready", 32'(r_tready), 0);
    chk("rst_o_tvalid", 32'(o_tvalid), 0);
    chk("rst_o_tdest", 32'(o_tdest), 0);
    ARESET  = 1'b0;
    r_valid = 1'b0;
    o_ready = 1'b0;

    // single job from requester 1
    lane(1, 1'b1, 16'h0005, 1'b0);
    #1 chk("t1_idle", 32'(s_tready), 0);
    step();
    chk("t1_grant", 32'(s_tready), 32'b0010);
    chk("t1_bias", 32'(m_tdata), 5);
    step();
    lane(1, 1'b1, 16'hF605, 1'b0);
    #1 chk("t1_pair0", 32'(m_tdata), 32'hF605);
    step();
    lane(1, 1'b1, 16'h1964, 1'b1);
    #1 chk("t1_last", 32'(m_tlast), 1);
    step();
    lane(1, 1'b0, 16'h0, 1'b0);
    #1 chk("t1_bubble", 32'(s_tready), 0);
    chk("t1_mac", res_q, 32'd2455);
    r_valid = 1'b1;
    r_data  = res_q;
    o_ready = 1'b1;
    #1 chk("t1_o_valid", 32'(o_tvalid), 1);
    chk("t1_o_data", o_tdata, 32'd2455);
    chk("t1_o_dest", 32'(o_tdest), 1);
    chk("t1_o_last", 32'(o_tlast), 1);
    chk("t1_r_ready", 32'(r_tready), 1);
    step();
    chk("t1_orphan_valid", 32'(o_tvalid), 0);
    chk("t1_orphan_ready", 32'(r_tready), 0);
    r_valid = 1'b0;
    o_ready = 1'b0;

    // round-robin among 0,2,3 until the tag FIFO fills
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    ord = '{2'd0, 2'd2, 2'd3, 2'd0};
    lane(0, 1'b1, 16'h0A00, 1'b0);
    lane(2, 1'b1, 16'h2A00, 1'b0);
    lane(3, 1'b1, 16'h3A00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_idle", 32'(s_tready), 0);
      step();
      chk("rr_grant", 32'(s_tready), 32'(1 << ord[k]));
      chk("rr_beat0", 32'(m_tdata), 32'({2'b00, ord[k], 12'hA00}));
      step();
      lane(ord[k], 1'b1, {2'b00, ord[k], 12'hA01}, 1'b1);
      #1 chk("rr_last", 32'(m_tlast), 1);
      chk("rr_beat1", 32'(m_tdata), 32'({2'b00, ord[k], 12'hA01}));
      step();
      lane(ord[k], 1'b1, {2'b00, ord[k], 12'hA00}, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk("full_block", 32'(s_tready), 0);
    end
    r_valid = 1'b1;
    r_data  = 32'h1111;
    o_ready = 1'b1;
    #1 chk("full_pop_valid", 32'(o_tvalid), 1);
    chk("full_pop_dest", 32'(o_tdest), 0);
    step();
    o_ready = 1'b0;
    #1 chk("full_bubble", 32'(s_tready), 0);
    chk("full_head", 32'(o_tdest), 2);
    step();
    chk("full_regrant", 32'(s_tready), 32'b0100);
    step();
    lane(2, 1'b1, 16'h2A01, 1'b1);
    step();
    for (int i = 0; i < N; i++) lane(2'(i), 1'b0, 16'h0, 1'b0);
    dq = '{2'd2, 2'd3, 2'd0, 2'd2};
    o_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("drain_dest", 32'(o_tdest), 32'(dq[k]));
      step();
    end
    chk("drain_empty", 32'(o_tvalid), 0);
    r_valid = 1'b0;
    o_ready = 1'b0;

    // mid-packet stall on requester 2
    lane(2, 1'b1, 16'hFBFC, 1'b0);
    step();
    chk("st_grant", 32'(s_tready), 32'b0100);
    step();
    lane(2, 1'b0, 16'h3D1E, 1'b0);
    lane(0, 1'b1, 16'h0A00, 1'b0);
    lane(3, 1'b1, 16'h3A00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("st_hold", 32'(s_tready), 32'b0100);
      chk("st_mvalid", 32'(m_tvalid), 0);
      step();
    end
    lane(2, 1'b1, 16'h3D1E, 1'b0);
    #1 chk("st_resume", 32'(m_tdata), 32'h3D1E);
    step();
    lane(2, 1'b1, 16'hEB11, 1'b0);
    step();
    lane(2, 1'b1, 16'h950D, 1'b1);
    #1 chk("st_last", 32'(m_tlast), 1);
    step();
    for (int i = 0; i < N; i++) lane(2'(i), 1'b0, 16'h0, 1'b0);
    #1 chk("st_mac", res_q, 32'hFFFF_FC4E);
    r_valid = 1'b1;
    r_data  = res_q;
    o_ready = 1'b1;
    #1 chk("st_dest", 32'(o_tdest), 2);
    chk("st_odata", o_tdata, 32'hFFFF_FC4E);
    step();
    r_valid = 1'b0;
    o_ready = 1'b0;

    // downstream backpressure toggling every cycle
    b  = 0;
    b0 = beats_q;
    mr = 1'b0;
    for (int c = 0; c < 20 && b < 2; c++) begin
      lane(1, 1'b1, (b == 0) ? 16'h1388 : 16'h8080, b == 1);
      m_ready = mr;
      mr = !mr;
      #1 hs = s_tready[1] & s_valid[1];
      step();
      if (hs) b++;
    end
    lane(1, 1'b0, 16'h0, 1'b0);
    m_ready = 1'b1;
    chk("bp_done", 32'(b), 2);
    chk("bp_beats", 32'(beats_q - b0), 2);
    chk("bp_mac", res_q, 32'd21384);
    r_valid = 1'b1;
    r_data  = res_q;
    o_ready = 1'b1;
    #1 chk("bp_dest", 32'(o_tdest), 1);
    step();
    r_valid = 1'b0;
    o_ready = 1'b0;

    // reset in the middle of a packet
    for (int i = 0; i < N; i++) lane(2'(i), 1'b1, 16'h0100, 1'b0);
    step();
    chk("rx_grant", 32'(s_tready), 32'b0100);
    step();
    ARESET = 1'b1;
    step();
    ARESET  = 1'b0;
    r_valid = 1'b1;
    o_ready = 1'b1;
    #1 chk("rx_s_tready", 32'(s_tready), 0);
    chk("rx_m_tvalid", 32'(m_tvalid), 0);
    chk("rx_m_tdata", 32'(m_tdata), 0);
    chk("rx_m_tlast", 32'(m_tlast), 0);
    chk("rx_o_tvalid", 32'(o_tvalid), 0);
    chk("rx_r_tready", 32'(r_tready), 0);
    chk("rx_o_tdest", 32'(o_tdest), 0);
    step();
    chk("rx_first_grant", 32'(s_tready), 32'b0001);
    r_valid = 1'b0;
    o_ready = 1'b0;
    for (int i = 0; i < N; i++) lane(2'(i), 1'b0, 16'h0, 1'b0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
